// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: state encoding, widths and the
// power-on contents of the branch-target LUT.
package fetch_unit_pkg;

  localparam int PC_W      = 10;
  localparam int LUT_N     = 8;
  localparam int LUT_IDX_W = $clog2(LUT_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

  // Entry i defaults to i*64 so every target is distinct and easy to spot.
  localparam logic [31:0] LUT_DEFAULT [LUT_N] = '{
    32'h000, 32'h040, 32'h080, 32'h0C0,
    32'h100, 32'h140, 32'h180, 32'h1C0
  };

  function automatic logic [31:0] lut_default(input int idx);
    if (idx >= 0 && idx < LUT_N) begin
      return LUT_DEFAULT[idx];
    end
    return 32'h0;
  endfunction

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// Branch-target register file: one synchronous write port, one combinational
// read port, entries restored to package defaults on reset.
module branch_lut #(
  parameter int PC_W  = fetch_unit_pkg::PC_W,
  parameter int LUT_N = fetch_unit_pkg::LUT_N,
  parameter int IDX_W = $clog2(LUT_N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [PC_W-1:0]  wr_data,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [PC_W-1:0]  rd_data
);
  import fetch_unit_pkg::*;

  logic [PC_W-1:0] entry_w [LUT_N];

  genvar gi;
  generate
    for (gi = 0; gi < LUT_N; gi++) begin : g_entry
      localparam logic [31:0] RST_VAL = lut_default(gi);
      logic [PC_W-1:0] entry_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          entry_q <= RST_VAL[PC_W-1:0];
        end else if (we && (wr_addr == IDX_W'(gi))) begin
          entry_q <= wr_data;
        end
      end

      assign entry_w[gi] = entry_q;
    end
  endgenerate

  // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
  assign rd_data = entry_w[rd_addr];

endmodule

// File: rtl/fetch_unit.sv
// Program counter sequencer: IDLE/RUN/DONE control with increment, stall,
// halt and LUT-indexed branch.
module fetch_unit #(
  parameter int PC_W  = fetch_unit_pkg::PC_W,
  parameter int LUT_N = fetch_unit_pkg::LUT_N
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stall,
  input  logic                     branch_en,
  input  logic [$clog2(LUT_N)-1:0] branch_idx,
  input  logic                     ctrl_ack_out,
  input  logic                     lut_we,
  input  logic [$clog2(LUT_N)-1:0] lut_addr,
  input  logic [PC_W-1:0]          lut_data,
  output logic [PC_W-1:0]          prog_ctr,
  output logic                     running,
  output logic                     done
);
  import fetch_unit_pkg::*;

  localparam int IDX_W = $clog2(LUT_N);

  fetch_state_e    state_q;
  logic [PC_W-1:0] pc_q;
  logic            running_q;
  logic            done_q;
  logic [PC_W-1:0] target_w;

  branch_lut #(
    .PC_W  (PC_W),
    .LUT_N (LUT_N),
    .IDX_W (IDX_W)
  ) u_lut (
    .clk     (clk),
    .reset   (reset),
    .we      (lut_we),
    .wr_addr (lut_addr),
    .wr_data (lut_data),
    .rd_addr (branch_idx),
    .rd_data (target_w)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          pc_q <= '0;
          if (start) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          // Halt outranks stall, which outranks branch; a stalled branch
          // is simply re-sampled once stall drops.
          if (ctrl_ack_out) begin
            state_q   <= DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (stall) begin
            pc_q <= pc_q;
          end else if (branch_en) begin
            pc_q <= target_w;
          end else begin
            pc_q <= pc_q + 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state_q   <= RUN;
            pc_q      <= '0;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          pc_q      <= '0;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign prog_ctr = pc_q;
  assign running  = running_q;
  assign done     = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stall;
  logic       branch_en;
  logic [2:0] branch_idx;
  logic       ctrl_ack_out;
  logic       lut_we;
  logic [2:0] lut_addr;
  logic [9:0] lut_data;
  logic [9:0] prog_ctr;
  logic       running;
  logic       done;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.PC_W(10), .LUT_N(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .branch_en    (branch_en),
    .branch_idx   (branch_idx),
    .ctrl_ack_out (ctrl_ack_out),
    .lut_we       (lut_we),
    .lut_addr     (lut_addr),
    .lut_data     (lut_data),
    .prog_ctr     (prog_ctr),
    .running      (running),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Outputs are sampled and inputs changed 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; stall = 0; branch_en = 0; branch_idx = 0;
    ctrl_ack_out = 0; lut_we = 0; lut_addr = 0; lut_data = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  // Start pulse then advance until prog_ctr == target (sequential only).
  task automatic start_and_run_to(input int target);
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < target; i++) tick();
    checks++;
    if (prog_ctr !== 10'(target)) begin
      errors++;
      $display("FAIL run_to: prog_ctr=%0d expected %0d", prog_ctr, target);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    #2;
    checks++;
    if (prog_ctr !== 10'd0 || running !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pc=%0d run=%b done=%b expected 0/0/0", prog_ctr, running, done);
    end
    tick();
    reset = 0;
    tick();
    tick();
    checks++;
    if (prog_ctr !== 10'd0 || running !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: pc=%0d run=%b done=%b expected 0/0/0", prog_ctr, running, done);
    end
    $display("test_reset: pc=%0d running=%b done=%b", prog_ctr, running, done);
  endtask

  task automatic test_sequential();
    do_reset();
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (prog_ctr !== 10'(i) || running !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL seq_pc%0d: pc=%0d run=%b done=%b expected %0d/1/0", i, prog_ctr, running, done, i);
      end
      $display("test_sequential: cycle %0d pc=%0d running=%b", i, prog_ctr, running);
      if (i < 4) tick();
    end
    start = 1;
    tick();
    start = 0;
    checks++;
    if (prog_ctr !== 10'd5 || running !== 1'b1) begin
      errors++;
      $display("FAIL start_in_run: pc=%0d run=%b expected 5/1", prog_ctr, running);
    end
  endtask

  task automatic test_branch();
    do_reset();
    lut_we = 1; lut_addr = 3; lut_data = 10'h1F0;
    tick();
    lut_we = 0;
    start_and_run_to(7);
    branch_en = 1; branch_idx = 3;
    tick();
    branch_en = 0;
    checks++;
    if (prog_ctr !== 10'h1F0) begin
      errors++;
      $display("FAIL branch_target: pc=0x%0h expected 0x1f0", prog_ctr);
    end
    tick();
    checks++;
    if (prog_ctr !== 10'h1F1) begin
      errors++;
      $display("FAIL branch_follow: pc=0x%0h expected 0x1f1", prog_ctr);
    end
    branch_en = 1; branch_idx = 5;
    tick();
    branch_en = 0;
    checks++;
    if (prog_ctr !== 10'h140) begin
      errors++;
      $display("FAIL branch_default5: pc=0x%0h expected 0x140", prog_ctr);
    end
    $display("test_branch: pc=0x%0h", prog_ctr);
  endtask

  task automatic test_halt();
    do_reset();
    start_and_run_to(12);
    ctrl_ack_out = 1; branch_en = 1; branch_idx = 3;
    tick();
    ctrl_ack_out = 0; branch_en = 0;
    checks++;
    if (done !== 1'b1 || running !== 1'b0 || prog_ctr !== 10'd12) begin
      errors++;
      $display("FAIL halt_enter: pc=%0d run=%b done=%b expected 12/0/1", prog_ctr, running, done);
    end
    branch_en = 1; ctrl_ack_out = 1;
    tick();
    tick();
    branch_en = 0; ctrl_ack_out = 0;
    checks++;
    if (done !== 1'b1 || prog_ctr !== 10'd12) begin
      errors++;
      $display("FAIL halt_hold: pc=%0d done=%b expected 12/1", prog_ctr, done);
    end
    start = 1;
    tick();
    start = 0;
    checks++;
    if (prog_ctr !== 10'd0 || running !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL restart: pc=%0d run=%b done=%b expected 0/1/0", prog_ctr, running, done);
    end
    tick();
    checks++;
    if (prog_ctr !== 10'd1) begin
      errors++;
      $display("FAIL restart_inc: pc=%0d expected 1", prog_ctr);
    end
    $display("test_halt: pc=%0d running=%b done=%b", prog_ctr, running, done);
  endtask

  task automatic test_wrap();
    do_reset();
    lut_we = 1; lut_addr = 1; lut_data = 10'h3FD;
    start = 1;
    tick();
    lut_we = 0; start = 0;
    branch_en = 1; branch_idx = 1;
    tick();
    branch_en = 0;
    for (int i = 0; i < 4; i++) begin
      automatic logic [9:0] exp_pc = 10'(10'h3FD + i);
      checks++;
      if (prog_ctr !== exp_pc || running !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL wrap%0d: pc=0x%0h run=%b expected 0x%0h/1", i, prog_ctr, running, exp_pc);
      end
      $display("test_wrap: pc=0x%0h running=%b", prog_ctr, running);
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    start_and_run_to(20);
    stall = 1; branch_en = 1; branch_idx = 3;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (prog_ctr !== 10'd20) begin
        errors++;
        $display("FAIL stall_hold%0d: pc=%0d expected 20", i, prog_ctr);
      end
    end
    stall = 0;
    tick();
    branch_en = 0;
    // lut[3] was rewritten earlier; reset must have restored 0x0C0.
    checks++;
    if (prog_ctr !== 10'h0C0) begin
      errors++;
      $display("FAIL stall_release: pc=0x%0h expected 0xc0", prog_ctr);
    end
    $display("test_stall: pc=0x%0h", prog_ctr);
  endtask

  task automatic test_async_reset();
    do_reset();
    start_and_run_to(40);
    #3;
    reset = 1;
    #1;
    checks++;
    if (prog_ctr !== 10'd0 || running !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: pc=%0d run=%b done=%b expected 0/0/0", prog_ctr, running, done);
    end
    tick();
    reset = 0;
    tick();
    tick();
    checks++;
    if (prog_ctr !== 10'd0 || running !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: pc=%0d run=%b expected 0/0", prog_ctr, running);
    end
    start_and_run_to(2);
    lut_we = 1; lut_addr = 3; lut_data = 10'h2AA;
    branch_en = 1; branch_idx = 3;
    tick();
    lut_we = 0;
    checks++;
    if (prog_ctr !== 10'h0C0) begin
      errors++;
      $display("FAIL same_cycle_write: pc=0x%0h expected 0xc0", prog_ctr);
    end
    tick();
    branch_en = 0;
    checks++;
    if (prog_ctr !== 10'h2AA) begin
      errors++;
      $display("FAIL written_entry: pc=0x%0h expected 0x2aa", prog_ctr);
    end
    $display("test_async_reset: pc=0x%0h", prog_ctr);
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_sequential();
    test_branch();
    test_halt();
    test_wrap();
    test_stall();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have these parameters, one per line (name, default, meaning):
  PC_W  10  program counter width; instruction ROM holds 2**PC_W words
  LUT_N  8  branch-target LUT entries; index width is log2(LUT_N)
REQ-002 The module SHALL have these ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock; all state updates on its rising edge
  reset  in  1  asynchronous, active-high reset
  start  in  1  one-cycle request to begin or restart a program
  stall  in  1  hold PC for this cycle while running
  branch_en  in  1  decoded branch-taken from control decoder
  branch_idx  in  3  LUT index, instruction[2:0] of the current break instruction
  ctrl_ack_out  in  1  decoder halt indication (current instruction is all-zero)
  lut_we  in  1  branch-target LUT write enable
  lut_addr  in  3  LUT write index
  lut_data  in  PC_W  LUT write value
  prog_ctr  out  PC_W  address presented to instruction ROM
  running  out  1  high while in RUN
  done  out  1  high while in DONE
REQ-003 The module SHALL use one clock, clk; reset SHALL be asynchronous and active-high.

Function
REQ-004 The module SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-005 IDLE: prog_ctr SHALL hold at 0; start=1 SHALL move the FSM to RUN, with prog_ctr=0 in the first RUN cycle.
REQ-006 RUN, in priority order: ctrl_ack_out=1 -> DONE, prog_ctr held; else stall=1 -> prog_ctr held; else branch_en=1 -> prog_ctr<=lut[branch_idx]; else prog_ctr<=prog_ctr+1.
REQ-007 prog_ctr+1 SHALL wrap modulo 2**PC_W (1023 -> 0 at default width), with no flag and no state change.
REQ-008 Halt SHALL take priority over a simultaneous branch_en; stall SHALL take priority over branch_en, and the branch is re-evaluated in the next unstalled cycle.
REQ-009 start SHALL be ignored in RUN.
REQ-010 DONE: prog_ctr SHALL hold the halting address; start=1 SHALL return the FSM to RUN with prog_ctr=0 in the next cycle.
REQ-011 Branch-target latency SHALL be one cycle: the PC value for the target appears the cycle after branch_en is sampled.
REQ-012 A LUT write SHALL take effect at the clock edge; a same-cycle branch reading the written index SHALL use the old entry.
REQ-013 LUT writes SHALL be accepted in every state.
REQ-014 running and done SHALL be registered decodes of state, mutually exclusive, and both low in IDLE.
REQ-015 branch_en and ctrl_ack_out SHALL be ignored outside RUN.

Reset
REQ-016 reset=1 SHALL immediately force state=IDLE, prog_ctr=0, running=0, done=0.
REQ-017 On reset, every LUT entry SHALL load its package default value.
REQ-018 Reset asserted mid-RUN SHALL abandon the program with no further PC update; a new start is required after deassertion.

Structure
REQ-019 The shared Definitions package SHALL hold the fetch-state enum (IDLE/RUN/DONE), PC_W, the LUT index width, and the default LUT contents array.
REQ-020 The branch-target LUT SHALL be a sub-module, branch_lut: an 8-entry register file with one synchronous write port, one combinational read port, and reset to package defaults.

Verification
REQ-021 Reset, start pulse, no branch/halt for 5 cycles -> prog_ctr sequence 0,1,2,3,4; running=1.
REQ-022 Write lut[3]=0x1F0, then in RUN at PC=7 drive branch_en=1, branch_idx=3 -> next prog_ctr=0x1F0, following cycle 0x1F1.
REQ-023 In RUN at PC=12 drive ctrl_ack_out=1 and branch_en=1 together -> DONE, done=1, prog_ctr stays 12; start -> RUN with prog_ctr=0.
REQ-024 Run to PC=1023 with no branch -> next prog_ctr=0, FSM still RUN.
REQ-025 stall=1 for 3 cycles at PC=20 with branch_en=1 -> prog_ctr holds 20; at stall release it takes lut[branch_idx].
REQ-026 Assert reset asynchronously mid-RUN at PC=40 -> prog_ctr=0 and state IDLE without a clock edge; a same-cycle write of lut_addr=3 while branching on index 3 uses the old value.
